nf_axis_metadata_tagger: RTL and testbench
==========================================

# nf_axis_metadata_tagger

Parametrised metadata inserter for the 10G receive path. It sits between the MAC RX AXI-Stream output and the input arbiter. It pairs each received frame with its entry from the MAC statistics FIFO and writes frame length and one-hot source port into TUSER of the first beat. Frames the MAC marks bad are discarded, and per-port packet, drop and length-error counters are maintained.

## Interface
Parameters:
- C_DATA_WIDTH, 64: TDATA width for both ports; must be 64 or 256.
- C_TUSER_WIDTH, 128: TUSER width for both ports.
- META_DATA_WIDTH, 30: stat FIFO word width.
- STAT_LEN_LSB, 5: LSB of the 15-bit length field in the stat word.
- STAT_GOOD_BIT, 1: index of the frame-good flag in the stat word.
- FCS_BYTES, 4: bytes subtracted from the stat length.
- NUM_PORTS, 4: number of valid source port numbers, 1..4.
- C_CNT_WIDTH, 32: counter width.

Ports:
- axis_aclk  in  1  clock for all logic.
- axis_reset  in  1  synchronous reset, active high.
- s_axis_tdata/tkeep/tuser/tvalid/tlast  in  C_DATA_WIDTH/C_DATA_WIDTH/8/C_TUSER_WIDTH/1/1  MAC RX stream.
- s_axis_tready  out  1  back-pressure to MAC.
- m_axis_tdata/tkeep/tuser/tvalid/tlast  out  as slave  tagged stream.
- m_axis_tready  in  1  downstream ready.
- stat_fifo_empty  in  1  stat FIFO empty; the FIFO is first-word-fall-through.
- stat_fifo_din  in  META_DATA_WIDTH  stat FIFO head word.
- stat_fifo_rden  out  1  stat FIFO pop, one cycle per frame.
- src_port_num  in  8  physical port index, static.
- pkt_cnt, drop_cnt, len_err_cnt  out  C_CNT_WIDTH each  statistics counters.

## Operation
State machine with states IDLE, HEAD, SEND and DROP.

- **IDLE**
  - Outputs: all m_axis outputs 0; s_axis_tready 0.
  - If ~stat_fifo_empty: stat_fifo_rden=1, and the length and good flag are latched from stat_fifo_din.
  - Next state is HEAD if the good flag is 1, else DROP.
- **HEAD**
  - m_axis data, keep, valid and last pass through combinationally; s_axis_tready=m_axis_tready.
  - m_axis_tuser = {zeros, 8'h00 dst, src_onehot[7:0], 1'b0, len[14:0]}.
  - Next state: IDLE on a tlast handshake; SEND on any other handshake; otherwise stay in HEAD.
- **SEND**
  - Same pass-through as HEAD, but m_axis_tuser=0.
  - Next state: IDLE on a tlast handshake.
- **DROP**
  - s_axis_tready=1 and m_axis_tvalid=0.
  - Next state: IDLE on s_axis_tvalid&s_axis_tlast.
  - drop_cnt increments at that beat.

Arithmetic and encoding:
- A handshake is s_axis_tvalid & m_axis_tready.
- len = stat_len - FCS_BYTES, saturating at 0 (stat_len < FCS_BYTES gives 0). len is 15 bits.
- src_onehot = 1<<(2*src_port_num) if src_port_num < NUM_PORTS, else 8'h01. Port 0 gives 8'h01; port 3 gives 8'h40.

Counters:
- pkt_cnt increments on every tlast handshake in HEAD or SEND.
- All counters wrap modulo 2^C_CNT_WIDTH.

Other rules:
- The stat FIFO is never popped outside IDLE. A non-empty FIFO in HEAD, SEND or DROP is ignored.
- The latched length is held until the next pop.

## Timing
- Data latency 0 cycles: combinational pass-through in HEAD and SEND.
- Exactly one IDLE bubble cycle per frame. Back-to-back frames need at least one idle cycle between last beat and next first beat.
- Reset values: state IDLE, all counters 0, latched length 0, latched good flag 0. Consequently every output is 0 the cycle after reset.
- Reset mid-frame: the block returns to IDLE with no output, and the remaining beats are left unconsumed. Upstream MAC and stat FIFO are reset in the same cycle.
- A single-beat frame (tlast in HEAD) goes HEAD→IDLE and carries the TUSER metadata.
- A tlast handshake and counter update in the same cycle as reset: reset wins.

## Configuration
- Macro: METADATA_LEN_CHECK_EN.
- When defined:
  - A 16-bit byte accumulator sums popcount(s_axis_tkeep) over every handshake in HEAD and SEND, and clears in IDLE.
  - On the tlast handshake the sum, including that beat, is compared with len. On mismatch, len_err_cnt increments.
  - The frame is still forwarded unchanged.
- When undefined: no accumulator logic exists, and len_err_cnt is constant 0.

## Test plan
- Reset, then stat word len=68 good=1, src_port_num=2, 64-byte frame (8 beats, tkeep=FF) with m_axis_tready=1:
  - one stat_fifo_rden pulse;
  - first-beat TUSER[15:0]=64 and TUSER[23:16]=8'h10, all later beats TUSER=0;
  - pkt_cnt=1.
- Same frame with m_axis_tready toggling 1/0 every cycle: output beats are identical, none duplicated or lost; the FSM holds HEAD until the first handshake.
- Stat word good=0 with a 3-beat frame: m_axis_tvalid stays 0, s_axis_tready=1 for all 3 beats, drop_cnt=1, pkt_cnt unchanged.
- Stat len=2 with a single-beat frame (tkeep=01, tlast=1): TUSER len=0 (saturated); FSM goes HEAD→IDLE; src_port_num=7 gives TUSER[23:16]=8'h01.
- With METADATA_LEN_CHECK_EN defined, stat len=68 but frame of 8 beats with last tkeep=0F (60 bytes): frame is forwarded and len_err_cnt=1. Without the macro, len_err_cnt remains 0.
- axis_reset asserted on beat 3 of 8: next cycle all outputs 0 and state IDLE, counters 0; after reset a fresh stat word and frame tag correctly.

Source files
------------

// File: rtl/nf_axis_metadata_tagger.sv
// Pairs each MAC RX frame with its stat FIFO word, tags TUSER of the first beat, drops bad frames.
// Optional frame byte-count check against the stat length: define METADATA_LEN_CHECK_EN.
//
// state | meaning
// IDLE  | bubble between frames; pops stat FIFO and latches length/good flag
// HEAD  | first beat of a good frame, TUSER carries length and source port
// SEND  | remaining beats of a good frame, TUSER zero
// DROP  | swallowing a bad frame without forwarding it
module nf_axis_metadata_tagger #(
  parameter int C_DATA_WIDTH    = 64,
  parameter int C_TUSER_WIDTH   = 128,
  parameter int META_DATA_WIDTH = 30,
  parameter int STAT_LEN_LSB    = 5,
  parameter int STAT_GOOD_BIT   = 1,
  parameter int FCS_BYTES       = 4,
  parameter int NUM_PORTS       = 4,
  parameter int C_CNT_WIDTH     = 32
) (
  input  logic                         axis_aclk,
  input  logic                         axis_reset,
  input  logic [C_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [C_DATA_WIDTH/8-1:0]    s_axis_tkeep,
  input  logic [C_TUSER_WIDTH-1:0]     s_axis_tuser,
  input  logic                         s_axis_tvalid,
  input  logic                         s_axis_tlast,
  output logic                         s_axis_tready,
  output logic [C_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0]    m_axis_tkeep,
  output logic [C_TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic                         m_axis_tvalid,
  output logic                         m_axis_tlast,
  input  logic                         m_axis_tready,
  input  logic                         stat_fifo_empty,
  input  logic [META_DATA_WIDTH-1:0]   stat_fifo_din,
  output logic                         stat_fifo_rden,
  input  logic [7:0]                   src_port_num,
  output logic [C_CNT_WIDTH-1:0]       pkt_cnt,
  output logic [C_CNT_WIDTH-1:0]       drop_cnt,
  output logic [C_CNT_WIDTH-1:0]       len_err_cnt
);

  localparam int KW = C_DATA_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_SEND, S_DROP} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [14:0] r_len;
  logic        r_good;

  logic [14:0] w_stat_len;
  logic [14:0] w_len_calc;
  logic        w_stat_good;
  logic [7:0]  w_onehot;
  logic        w_hs;
  logic        w_hs_last;
  logic        w_in_frame;

  assign w_stat_len  = stat_fifo_din[STAT_LEN_LSB +: 15];
  assign w_stat_good = stat_fifo_din[STAT_GOOD_BIT];
  // Runt stat lengths shorter than the FCS saturate to zero instead of wrapping
  assign w_len_calc  = (w_stat_len >= 15'(FCS_BYTES)) ? (w_stat_len - 15'(FCS_BYTES)) : 15'd0;
  assign w_hs        = s_axis_tvalid & m_axis_tready;
  assign w_hs_last   = w_hs & s_axis_tlast;
  assign w_in_frame  = (r_state == S_HEAD) || (r_state == S_SEND);

  always_comb begin
    w_onehot = 8'h01;
    if (src_port_num < 8'(NUM_PORTS)) begin
      w_onehot = 8'h01 << {src_port_num[1:0], 1'b0};
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    s_axis_tready  = 1'b0;
    m_axis_tdata   = '0;
    m_axis_tkeep   = '0;
    m_axis_tuser   = '0;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    stat_fifo_rden = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!stat_fifo_empty) begin
          stat_fifo_rden = 1'b1;
          w_state_nxt    = w_stat_good ? S_HEAD : S_DROP;
        end
      end
      S_HEAD: begin
        s_axis_tready = m_axis_tready;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tkeep  = s_axis_tkeep;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tlast  = s_axis_tlast;
        m_axis_tuser  = C_TUSER_WIDTH'({8'h00, w_onehot, 1'b0, r_len});
        if (w_hs) begin
          w_state_nxt = s_axis_tlast ? S_IDLE : S_SEND;
        end
      end
      S_SEND: begin
        s_axis_tready = m_axis_tready;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tkeep  = s_axis_tkeep;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tlast  = s_axis_tlast;
        if (w_hs_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DROP: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      r_state  <= S_IDLE;
      r_len    <= 15'd0;
      r_good   <= 1'b0;
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && !stat_fifo_empty) begin
        r_len  <= w_len_calc;
        r_good <= w_stat_good;
      end
      if (w_in_frame && r_good && w_hs_last) begin
        pkt_cnt <= pkt_cnt + C_CNT_WIDTH'(1);
      end
      if (r_state == S_DROP && s_axis_tvalid && s_axis_tlast) begin
        drop_cnt <= drop_cnt + C_CNT_WIDTH'(1);
      end
    end
  end

`ifdef METADATA_LEN_CHECK_EN
  logic [15:0] r_byte_acc;
  logic [15:0] w_beat_bytes;
  logic [15:0] w_frame_bytes;

  always_comb begin
    w_beat_bytes = 16'd0;
    for (int i = 0; i < KW; i++) begin
      w_beat_bytes = w_beat_bytes + 16'(s_axis_tkeep[i]);
    end
  end

  // Includes the current beat so the compare on tlast sees the whole frame
  assign w_frame_bytes = r_byte_acc + w_beat_bytes;

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      r_byte_acc  <= 16'd0;
      len_err_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_byte_acc <= 16'd0;
    end else if (w_in_frame && w_hs) begin
      r_byte_acc <= w_frame_bytes;
      if (s_axis_tlast && (w_frame_bytes != {1'b0, r_len})) begin
        len_err_cnt <= len_err_cnt + C_CNT_WIDTH'(1);
      end
    end
  end
`else
  assign len_err_cnt = '0;
`endif

endmodule

// File: tb/tb_nf_axis_metadata_tagger.sv
// Scoreboard bench for nf_axis_metadata_tagger: driver pushes expected beats, monitor pops on output handshakes.
module tb_nf_axis_metadata_tagger;

  logic         clk = 1'b0;
  logic         axis_reset;
  logic [63:0]  s_axis_tdata;
  logic [7:0]   s_axis_tkeep;
  logic [127:0] s_axis_tuser;
  logic         s_axis_tvalid;
  logic         s_axis_tlast;
  logic         s_axis_tready;
  logic [63:0]  m_axis_tdata;
  logic [7:0]   m_axis_tkeep;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tlast;
  logic         m_axis_tready;
  logic         stat_fifo_empty;
  logic [29:0]  stat_fifo_din;
  logic         stat_fifo_rden;
  logic [7:0]   src_port_num;
  logic [31:0]  pkt_cnt;
  logic [31:0]  drop_cnt;
  logic [31:0]  len_err_cnt;

  nf_axis_metadata_tagger dut (
    .axis_aclk       (clk),
    .axis_reset      (axis_reset),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tkeep    (s_axis_tkeep),
    .s_axis_tuser    (s_axis_tuser),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tready   (s_axis_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tkeep    (m_axis_tkeep),
    .m_axis_tuser    (m_axis_tuser),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tready   (m_axis_tready),
    .stat_fifo_empty (stat_fifo_empty),
    .stat_fifo_din   (stat_fifo_din),
    .stat_fifo_rden  (stat_fifo_rden),
    .src_port_num    (src_port_num),
    .pkt_cnt         (pkt_cnt),
    .drop_cnt        (drop_cnt),
    .len_err_cnt     (len_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]  d;
    logic [7:0]   k;
    logic         l;
    logic [127:0] u;
  } beat_t;

  beat_t exp_q[$];
  int nchk = 0;
  int nerr = 0;
  int exp_pkt = 0;
  int exp_drop = 0;
  int exp_lerr = 0;
  int exp_pops = 0;
  int pops = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!axis_reset && stat_fifo_rden) pops++;
  end

  // Monitor: every accepted output beat must match the head of the expected queue
  always @(negedge clk) begin
    if (!axis_reset && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL unexpected_beat: got data %0h with no beat expected at %0t", m_axis_tdata, $time);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        check("beat_data_keep_last", {55'd0, m_axis_tdata, m_axis_tkeep, m_axis_tlast},
              {55'd0, b.d, b.k, b.l});
        check("beat_tuser", m_axis_tuser, b.u);
      end
    end
  end

  task automatic check_counters(input string tag);
    check({tag, "_pkt_cnt"}, 128'(pkt_cnt), 128'(exp_pkt));
    check({tag, "_drop_cnt"}, 128'(drop_cnt), 128'(exp_drop));
    check({tag, "_len_err_cnt"}, 128'(len_err_cnt), 128'(exp_lerr));
  endtask

  task automatic send_frame(input logic [14:0] slen, input bit good, input logic [7:0] port,
                            input int nbeats, input logic [7:0] last_keep, input bit toggle,
                            input int reset_at);
    logic [14:0] len;
    logic [7:0]  oh;
    beat_t       b;
    int          bytes;
    int          budget;
    bit          acc;
    bit          tog;
    len = (slen >= 15'd4) ? (slen - 15'd4) : 15'd0;
    oh  = (port < 8'd4) ? (8'h01 << (2 * port)) : 8'h01;
    @(posedge clk); #1;
    src_port_num    = port;
    stat_fifo_din   = (30'(slen) << 5) | (good ? 30'd2 : 30'd0);
    stat_fifo_empty = 1'b0;
    m_axis_tready   = 1'b1;
    exp_pops++;
    @(negedge clk);
    check("rden_pulse", 128'(stat_fifo_rden), 128'd1);
    bytes = 0;
    tog   = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      @(posedge clk); #1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = {32'hDA7A0000 | 32'(i), 17'd0, slen};
      s_axis_tkeep  = (i == nbeats - 1) ? last_keep : 8'hFF;
      s_axis_tlast  = (i == nbeats - 1);
      s_axis_tuser  = {4{32'hBADC0DE5}};
      bytes += $countones(s_axis_tkeep);
      if (good) begin
        b.d = s_axis_tdata;
        b.k = s_axis_tkeep;
        b.l = s_axis_tlast;
        b.u = (i == 0) ? {96'd0, 8'h00, oh, 1'b0, len} : 128'd0;
        exp_q.push_back(b);
      end
      if (i == reset_at) begin
        axis_reset      = 1'b1;
        stat_fifo_empty = 1'b1;
        m_axis_tready   = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        axis_reset    = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        exp_q.delete();
        exp_pkt  = 0;
        exp_drop = 0;
        exp_lerr = 0;
        @(negedge clk);
        check("rst_m_tvalid", 128'(m_axis_tvalid), 128'd0);
        check("rst_m_tdata", 128'(m_axis_tdata), 128'd0);
        check("rst_s_tready", 128'(s_axis_tready), 128'd0);
        check("rst_rden", 128'(stat_fifo_rden), 128'd0);
        check_counters("rst");
        return;
      end
      acc    = 1'b0;
      budget = 0;
      while (!acc) begin
        m_axis_tready = toggle ? tog : 1'b1;
        tog = !tog;
        @(negedge clk);
        if (!good) check("drop_s_tready", 128'(s_axis_tready), 128'd1);
        acc = s_axis_tready;
        if (!acc) begin
          budget++;
          if (budget > 16) begin
            nchk++;
            nerr++;
            $display("FAIL beat_timeout: beat %0d not accepted, required within 16 cycles", i);
            acc = 1'b1;
          end else begin
            @(posedge clk); #1;
          end
        end
      end
    end
    @(posedge clk); #1;
    s_axis_tvalid   = 1'b0;
    s_axis_tlast    = 1'b0;
    stat_fifo_empty = 1'b1;
    m_axis_tready   = 1'b1;
    if (good) exp_pkt++;
    else exp_drop++;
`ifdef METADATA_LEN_CHECK_EN
    if (good && bytes != int'(len)) exp_lerr++;
`endif
    @(negedge clk);
    check("idle_m_tvalid", 128'(m_axis_tvalid), 128'd0);
    check("idle_s_tready", 128'(s_axis_tready), 128'd0);
    check("beats_outstanding", 128'(exp_q.size()), 128'd0);
    check("pop_count", 128'(pops), 128'(exp_pops));
    check_counters("frame");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    axis_reset      = 1'b1;
    s_axis_tdata    = '0;
    s_axis_tkeep    = '0;
    s_axis_tuser    = '0;
    s_axis_tvalid   = 1'b0;
    s_axis_tlast    = 1'b0;
    m_axis_tready   = 1'b1;
    stat_fifo_empty = 1'b1;
    stat_fifo_din   = '0;
    src_port_num    = 8'd2;
    repeat (3) @(posedge clk);
    #1 axis_reset = 1'b0;
    @(negedge clk);
    check("reset_m_tvalid", 128'(m_axis_tvalid), 128'd0);
    check("reset_m_tuser", m_axis_tuser, 128'd0);
    check("reset_s_tready", 128'(s_axis_tready), 128'd0);
    check("reset_rden", 128'(stat_fifo_rden), 128'd0);
    check_counters("reset");

    // 64-byte good frame, port 2: TUSER 0x00100040 on the first beat
    send_frame(15'd68, 1'b1, 8'd2, 8, 8'hFF, 1'b0, -1);
    // Same frame with downstream ready toggling
    send_frame(15'd68, 1'b1, 8'd2, 8, 8'hFF, 1'b1, -1);
    // Bad frame: dropped, stat FIFO stays non-empty throughout
    send_frame(15'd68, 1'b0, 8'd2, 3, 8'hFF, 1'b0, -1);
    // Runt length saturates, out-of-range port maps to one-hot 0x01
    send_frame(15'd2, 1'b1, 8'd7, 1, 8'h01, 1'b0, -1);
    // Short last beat: 60 bytes against length 64
    send_frame(15'd68, 1'b1, 8'd2, 8, 8'h0F, 1'b0, -1);
    // Port 3 gives one-hot 0x40, 16-byte frame matches its length
    send_frame(15'd20, 1'b1, 8'd3, 2, 8'hFF, 1'b1, -1);
    // Reset on the third beat, then a fresh frame on port 0
    send_frame(15'd68, 1'b1, 8'd1, 8, 8'hFF, 1'b0, 2);
    send_frame(15'd36, 1'b1, 8'd0, 4, 8'hFF, 1'b0, -1);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
